// File: rtl/pdm_capture_fifo.sv
// PDM microphone front end: bit clock generation, mono/stereo capture,
// boxcar decimation to signed PCM and a first-word-fall-through sample FIFO.
module pdm_capture_fifo #(
    parameter int DECIM    = 64,
    parameter int CHANNELS = 1,
    parameter int DEPTH    = 16,
    parameter int SAMPLE_W = 8
) (
    input  logic                       mclk,
    input  logic                       reset,
    input  logic                       en,
    output logic                       pdm_clk,
    output logic                       pdm_lrsel,
    input  logic                       pdm_data,
    output logic [SAMPLE_W-1:0]        m_data,
    output logic                       m_chan,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       ovf_clr
);

    localparam int PW = $clog2(DECIM);
    localparam int OW = PW + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int WW = SAMPLE_W + 1;
    localparam bit STEREO = (CHANNELS == 2);

    logic          r_pdm_clk;
    logic [PW-1:0] r_period;
    logic [OW-1:0] r_ones_l;
    logic [OW-1:0] r_ones_r;
    logic          r_wr_en;
    logic [WW-1:0] r_wr_word;
    logic [WW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;

    logic                w_cap_l;
    logic                w_cap_r;
    logic                w_last_l;
    logic                w_last_r;
    logic [OW-1:0]       w_ones_l;
    logic [OW-1:0]       w_ones_r;
    logic [SAMPLE_W-1:0] w_samp_l;
    logic [SAMPLE_W-1:0] w_samp_r;
    logic                w_full;
    logic                w_valid;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    // L is sampled on the rising bit-clock edge, R on the falling one
    assign w_cap_l  = en & ~r_pdm_clk;
    assign w_cap_r  = en & r_pdm_clk & STEREO;
    assign w_last_l = w_cap_l && (r_period == PW'(DECIM - 1));
    assign w_last_r = w_cap_r && (r_period == '0);
    assign w_ones_l = r_ones_l + OW'(pdm_data);
    assign w_ones_r = r_ones_r + OW'(pdm_data);
    assign w_samp_l = SAMPLE_W'({w_ones_l, 1'b0}) - SAMPLE_W'(DECIM);
    assign w_samp_r = SAMPLE_W'({w_ones_r, 1'b0}) - SAMPLE_W'(DECIM);

    always_ff @(posedge mclk) begin
        if (reset || !en) begin
            r_pdm_clk <= 1'b0;
            r_period  <= '0;
            r_ones_l  <= '0;
            r_ones_r  <= '0;
        end else begin
            r_pdm_clk <= ~r_pdm_clk;
            if (w_cap_l) begin
                r_period <= w_last_l ? '0 : r_period + PW'(1);
                r_ones_l <= w_last_l ? '0 : w_ones_l;
            end
            if (w_cap_r) begin
                r_ones_r <= w_last_r ? '0 : w_ones_r;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_wr_word <= '0;
        end else begin
            r_wr_en   <= w_last_l | w_last_r;
            r_wr_word <= w_last_r ? {1'b1, w_samp_r} : {1'b0, w_samp_l};
        end
    end

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_valid = (r_level != '0);
    assign w_pop   = w_valid & m_ready;
    assign w_push  = r_wr_en & (~w_full | w_pop);
    assign w_drop  = r_wr_en & w_full & ~w_pop;

    always_ff @(posedge mclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_wr_word;
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // a drop in the same cycle as a clear wins so no loss goes unreported
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign pdm_clk   = r_pdm_clk;
    assign pdm_lrsel = 1'b0;
    assign m_valid   = w_valid;
    assign m_data    = w_valid ? r_mem[r_rptr][SAMPLE_W-1:0] : '0;
    assign m_chan    = w_valid & r_mem[r_rptr][SAMPLE_W];
    assign level     = r_level;
    assign full      = w_full;
    assign empty     = ~w_valid;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_pdm_capture_fifo.sv
// Randomised scoreboard bench for pdm_capture_fifo (stereo, DECIM=8, DEPTH=4).
module tb_pdm_capture_fifo;

    localparam int DECIM = 8;
    localparam int DEPTH = 4;
    localparam int SW    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          mclk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          pdm_data = 1'b0;
    logic          m_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          pdm_clk;
    logic          pdm_lrsel;
    logic [SW-1:0] m_data;
    logic          m_chan;
    logic          m_valid;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          overflow;

    always #5 mclk = ~mclk;

    pdm_capture_fifo #(
        .DECIM(DECIM), .CHANNELS(2), .DEPTH(DEPTH), .SAMPLE_W(SW)
    ) dut (
        .mclk(mclk), .reset(reset), .en(en),
        .pdm_clk(pdm_clk), .pdm_lrsel(pdm_lrsel), .pdm_data(pdm_data),
        .m_data(m_data), .m_chan(m_chan), .m_valid(m_valid),
        .m_ready(m_ready), .level(level), .full(full), .empty(empty),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // reference model: bit lists per channel, an occupancy count and the
    // expected word stream (scoreboard) that the monitor consumes
    bit         ph;
    bit         lq[$];
    bit         rq[$];
    bit         pend;
    logic [8:0] pend_w;
    int         occ;
    bit         ovf;
    bit         started = 1'b0;
    bit         mpop;
    bit         macc;
    logic [8:0] expq[$];

    function automatic logic [8:0] mk(input bit ch, input bit q[$]);
        int ones = 0;
        int s;
        logic [SW-1:0] v;
        foreach (q[i]) ones += int'(q[i]);
        s = 2 * ones - DECIM;
        v = s[SW-1:0];
        return {ch, v};
    endfunction

    always @(posedge mclk) begin
        if (reset) begin
            ph = 1'b0;
            lq.delete();
            rq.delete();
            pend = 1'b0;
            occ = 0;
            ovf = 1'b0;
            expq.delete();
            started = 1'b1;
        end else if (started) begin
            mpop = (occ > 0) && m_ready;
            if (mpop) occ--;
            macc = 1'b0;
            if (pend) begin
                if (occ < DEPTH) begin
                    occ++;
                    expq.push_back(pend_w);
                    macc = 1'b1;
                end
            end
            if (pend && !macc) ovf = 1'b1;
            else if (ovf_clr) ovf = 1'b0;
            pend = 1'b0;
            if (en) begin
                if (!ph) begin
                    lq.push_back(pdm_data);
                    if (lq.size() == DECIM) begin
                        pend = 1'b1;
                        pend_w = mk(1'b0, lq);
                        lq.delete();
                    end
                end else begin
                    rq.push_back(pdm_data);
                    if (rq.size() == DECIM) begin
                        pend = 1'b1;
                        pend_w = mk(1'b1, rq);
                        rq.delete();
                    end
                end
                ph = ~ph;
            end else begin
                ph = 1'b0;
                lq.delete();
                rq.delete();
            end
        end
    end

    // monitor: status every cycle, head word on each handshake
    always @(negedge mclk) begin
        if (started) begin
            chk("pdm_clk", int'(pdm_clk), int'(ph));
            chk("pdm_lrsel", int'(pdm_lrsel), 0);
            chk("m_valid", int'(m_valid), int'(occ > 0));
            chk("level", int'(level), occ);
            chk("full", int'(full), int'(occ == DEPTH));
            chk("empty", int'(empty), int'(occ == 0));
            chk("overflow", int'(overflow), int'(ovf));
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    chk("head_unexpected", 1, 0);
                end else begin
                    chk("head_word", int'({m_chan, m_data}), int'(expq.pop_front()));
                end
            end
        end
    end

    bit alt = 1'b0;

    // modes: 0 random, 1 all ones, 2 L=1 R=0, 3 L alternating, 4 all zeros
    task automatic cyc(input int n, input int mode, input int rdy, input int clr);
        for (int i = 0; i < n; i++) begin
            @(posedge mclk);
            #1;
            unique case (mode)
                1: pdm_data = 1'b1;
                2: pdm_data = ~ph;
                3: begin
                    if (!ph) alt = ~alt;
                    pdm_data = ph ? 1'($urandom_range(1)) : alt;
                end
                4: pdm_data = 1'b0;
                default: pdm_data = 1'($urandom_range(1));
            endcase
            m_ready = ($urandom_range(99) < rdy);
            ovf_clr = ($urandom_range(99) < clr);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pdm_clk"}, int'(pdm_clk), 0);
        chk({tag, "_lrsel"}, int'(pdm_lrsel), 0);
        chk({tag, "_m_valid"}, int'(m_valid), 0);
        chk({tag, "_m_data"}, int'(m_data), 0);
        chk({tag, "_m_chan"}, int'(m_chan), 0);
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_full"}, int'(full), 0);
        chk({tag, "_empty"}, int'(empty), 1);
        chk({tag, "_overflow"}, int'(overflow), 0);
    endtask

    int k;
    int saved;

    initial begin
        repeat (3) @(posedge mclk);
        #1;
        chk_reset("rst");
        reset = 1'b0;
        en = 1'b1;
        cyc(40, 1, 100, 0);
        cyc(64, 2, 100, 0);
        cyc(48, 3, 100, 0);
        cyc(48, 4, 100, 0);

        cyc(120, 1, 0, 0);
        chk("stall_level", int'(level), DEPTH);
        chk("stall_full", int'(full), 1);
        chk("stall_overflow", int'(overflow), 1);
        cyc(1, 1, 0, 100);
        cyc(30, 0, 100, 0);
        cyc(400, 0, 12, 6);
        cyc(40, 0, 100, 0);

        k = 0;
        while (lq.size() != 3 && k < 100) begin
            cyc(1, 0, 100, 0);
            k++;
        end
        chk("wait_mid_sample", int'(k < 100), 1);
        @(posedge mclk);
        #1;
        reset = 1'b1;
        @(posedge mclk);
        #1;
        chk_reset("midrst");
        reset = 1'b0;
        cyc(60, 1, 100, 0);

        k = 0;
        while (occ < 2 && k < 100) begin
            cyc(1, 0, 0, 0);
            k++;
        end
        while (lq.size() != 3 && k < 200) begin
            cyc(1, 0, 0, 0);
            k++;
        end
        chk("wait_queued", int'(k < 200), 1);
        saved = occ;
        en = 1'b0;
        cyc(20, 1, 0, 0);
        chk("dis_pdm_clk", int'(pdm_clk), 0);
        chk("dis_level", int'(level), saved);
        cyc(10, 1, 100, 0);
        chk("dis_drained", int'(empty), 1);
        en = 1'b1;
        cyc(80, 0, 70, 0);
        cyc(30, 0, 100, 0);
        chk("scoreboard_empty", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pdm_capture_fifo.md
# pdm_capture_fifo

Parametrised PDM microphone front end: generates the microphone bit clock and L/R select, deserialises one or two PDM channels, decimates each by boxcar counting into signed PCM samples and buffers them in an internal first-word-fall-through FIFO with a valid/ready output. It sits between the board microphone pins and the audio playback/processing path. It replaces the fixed single-bit capture-plus-toggle scheme with configurable decimation, channel count and buffer depth, plus overflow reporting.

## Interface
- DECIM, 64: PDM bits per output sample per channel; power of two, 4..256
- CHANNELS, 1: 1 = mono (left only), 2 = stereo on shared data line
- DEPTH, 16: FIFO words; power of two, 2..64
- SAMPLE_W, 8: signed sample width; must be ≥ log2(DECIM)+2
- mclk  in  1  block clock; runs at 2× PDM bit rate
- reset  in  1  synchronous, active-high
- en  in  1  capture enable
- pdm_clk  out  1  microphone bit clock (mclk/2)
- pdm_lrsel  out  1  microphone L/R select; constant 0
- pdm_data  in  1  PDM data from microphone(s)
- m_data  out  SAMPLE_W  FIFO head sample, signed two's complement
- m_chan  out  1  FIFO head channel (0 = L, 1 = R)
- m_valid  out  1  FIFO not empty
- m_ready  in  1  consumer accepts head word
- level  out  log2(DEPTH)+1  words stored
- full, empty  out  1  FIFO status
- overflow  out  1  sticky: sample dropped on full FIFO
- ovf_clr  in  1  clears overflow

## Operation
- Reset values: pdm_clk 0, pdm_lrsel 0, m_valid 0, m_data 0, m_chan 0, level 0, full 0, empty 1, overflow 0; all counters and accumulators 0; FIFO emptied.
- en=1: pdm_clk toggles every mclk. en=0: pdm_clk forced 0 on the next edge; bit counter and both accumulators cleared (partial samples discarded); FIFO contents and overflow retained; reads continue.
- Capture: L bit = pdm_data on the mclk edge that drives pdm_clk 0→1; R bit (CHANNELS=2 only) = pdm_data on the edge that drives pdm_clk 1→0.
- Per channel, ones counter (width log2(DECIM)+1) adds captured bit; shared period counter counts 0..DECIM-1, advancing on each L capture, wraps to 0.
- Sample = 2·ones − DECIM, sign-extended to SAMPLE_W; range −DECIM..+DECIM. All ones → +DECIM, all zeros → −DECIM, 50% density → 0.
- On the final (DECIM-th) capture of a channel, its sample (including that bit) is written to the FIFO and that ones counter restarts from 0; next bit counts toward the new sample.
- Word = {chan, sample}; at most one write per mclk (L and R completions are one mclk apart).
- FIFO read: when m_valid && m_ready the head is popped; next word (if any) appears on m_data/m_chan the following cycle.
- Write with full=1 and no pop in same cycle: word dropped, overflow set. Write with full=1 and simultaneous pop: write accepted, level unchanged.
- ovf_clr clears overflow; simultaneous set and clear → overflow stays 1.

## Timing
- Write latency: word enters FIFO on the edge after the final capture; m_valid rises on that edge if FIFO was empty (1 mclk after final capture).
- Sample period per channel: 2·DECIM mclk. Stereo: R word written exactly 1 mclk after L word.
- level, full, empty, m_valid update on the same edge as the push/pop causing them; simultaneous push and pop leave level unchanged.
- m_data/m_chan stable while m_valid=1 and m_ready=0.
- Reset mid-sample or mid-transfer: all state reset next edge; partial sample lost; no spurious write.
- en rising: first L capture on the first edge driving pdm_clk 0→1 (1 mclk after en seen).

## Test plan
- DECIM=8, CHANNELS=1, pdm_data=1 constant, m_ready=1 → words {0,+8} every 16 mclk; pdm_clk period 2 mclk; pdm_lrsel=0.
- DECIM=8, alternating 1,0 on L captures → every sample 0; all zeros → −8 (0xF8 at SAMPLE_W=8).
- CHANNELS=2, L bits all 1, R bits all 0 → alternating {0,+8},{1,−8}; R written 1 mclk after L.
- DEPTH=4, m_ready=0 for 6 samples → level=4, full=1, overflow=1, first 4 words preserved in order; ovf_clr pulse → overflow 0; pop and write same cycle while full → accepted, level stays 4.
- reset asserted 3 bits into a sample → all outputs at reset values next edge; after release, first word needs full DECIM bits.
- en dropped mid-sample with 2 words queued → pdm_clk 0, no new writes, queued words still readable; re-enable → fresh sample counts from 0.
